dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of the byte-addressable, big-endian DataMemory.
//  Port 0 is the CPU load/store unit. Port 1 is the DMA/debug loader.
//  At most one word access is granted per cycle; it drives memread/memwrite/addr/write_data to
//  the memory and routes the registered read data back to the port that issued it.
//  Illegal accesses (misaligned, out of range) are blocked before they reach memory.
// PARAMETERS
//  MEM_BYTES  128  memory size in bytes; legal addr satisfies addr+3 < MEM_BYTES
//  FIXED_PRI  0    0 = round-robin between ports; 1 = port 0 always wins
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  reset         in   1   synchronous, active-high reset
//  req0/req1     in   1   port requests a word access this cycle
//  we0/we1       in   1   1 = write, 0 = read
//  addr0/addr1   in   32  byte address
//  wdata0/wdata1 in   32  write data
//  gnt0/gnt1     out  1   combinational grant; the access is accepted this cycle
//  rvalid0/1     out  1   registered; read response (or error) for the port, one cycle after its grant
//  rdata0/1      out  32  read data, valid with rvalid; 0 when err
//  err0/err1     out  1   registered; accepted access was illegal (pulses with rvalid, or alone for a write)
//  mem_addr      out  32  to DataMemory addr
//  mem_wdata     out  32  to DataMemory write_data
//  mem_read      out  1   to DataMemory memread
//  mem_write     out  1   to DataMemory memwrite
//  mem_rdata     in   32  from DataMemory read_data
// BEHAVIOUR
//  Reset (synchronous, while reset=1):
//   - gnt*, mem_read, mem_write are forced to 0.
//   - rvalid*, err*, rdata* = 0.
//   - RR pointer last=1, so port 0 wins the first contention.
//   - Any pending response is dropped.
//  Grant (combinational, cycle N):
//   - Only one requester: that port is granted.
//   - Both request, FIXED_PRI=0: grant the port != last. Update last <= winner at posedge.
//   - Both request, FIXED_PRI=1: grant port 0; last is unused.
//   - A requester must hold req/we/addr/wdata stable until it sees gnt.
//  Memory drive for the winner:
//   - mem_addr, mem_wdata copy the winner's addr/wdata.
//   - mem_read = ~we & legal; mem_write = we & legal.
//   - With no grant: mem_read = mem_write = 0, mem_addr = mem_wdata = 0.
//  legal = (addr[1:0]==0) && (addr <= MEM_BYTES-4). An illegal access is still granted but never reaches memory.
//  Response pipeline, one stage:
//   - Register {valid, owner, is_read, illegal} at the posedge that ends cycle N.
//   - Legal read: in cycle N+1, rvalid_owner=1 and rdata_owner = mem_rdata (memory registered it at that same edge).
//   - Illegal read: in cycle N+1, rvalid=1, err=1, rdata=0.
//   - Legal write: completes at the negedge inside cycle N; no rvalid.
//   - Illegal write: err pulses for 1 cycle in N+1; rvalid stays 0.
//  Back-to-back grants every cycle are allowed; throughput is 1 access per cycle.
//  Read-after-write to the same address in consecutive cycles returns the new data (the write lands at the negedge first).
//  reset asserted in the cycle after a read grant: rvalid suppressed, response lost.
//  rdata of the non-owner port holds 0.
// STRUCTURE
//  dmem_arb_pkg holds:
//   - localparam PORT_CPU=0, PORT_DMA=1.
//   - The response-tag struct/field widths.
//   - The legality function.
//  Sub-module rr_arb2: 2-way round-robin with a FIXED_PRI option and a registered last pointer.
//  Response pipeline and muxing live in the top module.
// TESTING
//  1. Reset, then req0 read addr=8 with MEM[8..11]=DE AD BE EF:
//     gnt0=1 in cycle 0; rvalid0=1, rdata0=32'hDEADBEEF in cycle 1; rvalid1=0.
//  2. req0 and req1 both read every cycle for 4 cycles, FIXED_PRI=0:
//     grants go 0,1,0,1; each rvalid arrives with its owner's data one cycle later.
//  3. Same stimulus with FIXED_PRI=1: gnt0 every cycle, gnt1 never; req1 held stable with no grant.
//  4. Port1 writes 32'h12345678 to addr 4 in cycle 0, then port0 reads addr 4 in cycle 1:
//     rdata0=32'h12345678 in cycle 2.
//  5. Illegal accesses:
//     - Read addr=6 (misaligned): mem_read=0; err0=rvalid0=1, rdata0=0 next cycle.
//     - Write addr=128: mem_write=0; err pulses next cycle with rvalid=0.
//  6. Read granted in cycle 0, reset=1 in cycle 1: rvalid0=0 in cycle 1; after reset, both requesting gives port 0 the first grant.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Port ids, response tag layout and the access legality check.
package dmem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic is_read;
    logic illegal;
  } rsp_tag_t;

  // Word aligned and the whole word fits inside the memory.
  function automatic logic is_legal(
    input logic [ADDR_W-1:0] addr,
    input int unsigned       mem_bytes
  );
    logic [ADDR_W-1:0] lim;
    lim = ADDR_W'(mem_bytes - 4);
    return (addr[1:0] == 2'b00) && (addr <= lim);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and DataMemory.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;

  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata0, rdata1, err0, err1,
    output mem_addr, mem_wdata,
    output mem_read, mem_write
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata0, rdata1, err0, err1,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on contention, or fixed port-0 priority.
// last_q only moves when both ports contend.
module rr_arb2
  import dmem_arb_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;
  logic win;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    win    = PORT_CPU;
    if (!reset_i) begin
      unique case (1'b1)
        (req_i == 2'b11): begin
          win = FIXED_PRI ? PORT_CPU : ~last_q;
          gnt_o[win] = 1'b1;
          if (!FIXED_PRI) last_d = win;
        end
        (req_i == 2'b01): gnt_o = 2'b01;
        (req_i == 2'b10): gnt_o = 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) last_q <= PORT_DMA;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the big-endian DataMemory.
// One word access per cycle; single-stage response pipeline.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              legal;
  rsp_tag_t          tag_d;
  rsp_tag_t          tag_q;
  logic              live;
  logic              own0;
  logic              own1;

  assign req = {bus.req1, bus.req0};

  rr_arb2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_arb (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   (req),
    .gnt_o   (gnt)
  );

  assign any      = |gnt;
  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      gnt[0]: begin
        sel_we    = bus.we0;
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
      end
      gnt[1]: begin
        sel_we    = bus.we1;
        sel_addr  = bus.addr1;
        sel_wdata = bus.wdata1;
      end
      default: ;
    endcase
  end

  assign legal = is_legal(sel_addr, MEM_BYTES);

  // Illegal accesses are still granted but never reach memory.
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_read  = any & ~sel_we & legal;
  assign bus.mem_write = any &  sel_we & legal;

  always_comb begin
    tag_d         = '0;
    tag_d.valid   = any;
    tag_d.owner   = gnt[1];
    tag_d.is_read = ~sel_we;
    tag_d.illegal = ~legal;
  end

  always_ff @(posedge clk) begin
    if (reset) tag_q <= '0;
    else       tag_q <= tag_d;
  end

  // Reset in the response cycle drops the response immediately.
  assign live = tag_q.valid & ~reset;
  assign own0 = live & (tag_q.owner == PORT_CPU);
  assign own1 = live & (tag_q.owner == PORT_DMA);

  assign bus.rvalid0 = own0 & tag_q.is_read;
  assign bus.rvalid1 = own1 & tag_q.is_read;
  assign bus.err0    = own0 & tag_q.illegal;
  assign bus.err1    = own1 & tag_q.illegal;

  assign bus.rdata0 = (bus.rvalid0 & ~tag_q.illegal) ?
                      bus.mem_rdata : '0;
  assign bus.rdata1 = (bus.rvalid1 & ~tag_q.illegal) ?
                      bus.mem_rdata : '0;

endmodule
